// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped, write-back, write-allocate cache controller that sequences an external single-port data array.
// Define CACHE_STATS_EN to add the hit_cnt_o/miss_cnt_o request counters.
module cache_ctrl_fsm #(
  parameter  int DEPTH   = 1024,
  parameter  int ADDR_W  = 32,
  parameter  int BLOCK_W = 128,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int OFF_W   = $clog2(BLOCK_W / 8),
  localparam int TAG_W   = ADDR_W - IDX_W - OFF_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cpu_valid_i,
  input  logic               cpu_rw_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [31:0]        cpu_wdata_i,
  output logic [31:0]        cpu_rdata_o,
  output logic               cpu_ready_o,
  output logic [IDX_W-1:0]   data_index_o,
  output logic               data_we_o,
  output logic [BLOCK_W-1:0] data_write_o,
  input  logic [BLOCK_W-1:0] data_read_i,
  output logic               mem_valid_o,
  output logic               mem_rw_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_wdata_o,
  input  logic [BLOCK_W-1:0] mem_rdata_i,
  input  logic               mem_ready_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITE_BACK,
    S_ALLOCATE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q [DEPTH];
  logic                tag_we;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]    cur_idx;
  logic [TAG_W-1:0]    cur_tag;
  logic [OFF_W-3:0]    word_sel;
  logic                hit;
  logic                victim_dirty;
  logic [BLOCK_W-1:0]  merged_line;
  logic                unused_addr_lsbs;

  assign cur_idx          = addr_q[OFF_W +: IDX_W];
  assign cur_tag          = addr_q[ADDR_W-1 -: TAG_W];
  assign word_sel         = addr_q[OFF_W-1:2];
  assign hit              = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign victim_dirty     = valid_q[cur_idx] && dirty_q[cur_idx];
  assign unused_addr_lsbs = ^addr_q[1:0];

  always_comb begin
    merged_line = data_read_i;
    merged_line[{word_sel, 5'b0} +: 32] = wdata_q;
  end

  // NOTE: every signal written below gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_we       = 1'b0;
    mem_valid_d  = mem_valid_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ready_o  = 1'b0;
    cpu_rdata_o  = '0;
    data_we_o    = 1'b0;
    data_write_o = '0;
    data_index_o = (state_q == S_IDLE) ? cpu_addr_i[OFF_W +: IDX_W] : cur_idx;

    case (state_q)
      S_IDLE: begin
        if (cpu_valid_i) begin
          addr_d  = cpu_addr_i;
          rw_d    = cpu_rw_i;
          wdata_d = cpu_wdata_i;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          cpu_ready_o = 1'b1;
          if (rw_q) begin
            data_we_o         = 1'b1;
            data_write_o      = merged_line;
            dirty_d[cur_idx]  = 1'b1;
          end else begin
            cpu_rdata_o = data_read_i[{word_sel, 5'b0} +: 32];
          end
          state_d = S_IDLE;
        end else begin
          // The victim line is captured now; the array will be overwritten by the fill.
          mem_valid_d = 1'b1;
          mem_wdata_d = data_read_i;
          if (victim_dirty) begin
            mem_rw_d   = 1'b1;
            mem_addr_d = {tag_q[cur_idx], cur_idx, {OFF_W{1'b0}}};
            state_d    = S_WRITE_BACK;
          end else begin
            mem_rw_d   = 1'b0;
            mem_addr_d = {cur_tag, cur_idx, {OFF_W{1'b0}}};
            state_d    = S_ALLOCATE;
          end
        end
      end
      S_WRITE_BACK: begin
        if (mem_ready_i) begin
          dirty_d[cur_idx] = 1'b0;
          mem_rw_d         = 1'b0;
          mem_addr_d       = {cur_tag, cur_idx, {OFF_W{1'b0}}};
          state_d          = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        if (mem_ready_i) begin
          data_we_o        = 1'b1;
          data_write_o     = mem_rdata_i;
          valid_d[cur_idx] = 1'b1;
          dirty_d[cur_idx] = 1'b0;
          tag_we           = 1'b1;
          mem_valid_d      = 1'b0;
          state_d          = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // NOTE: the tag array has no reset; a tag is only ever read behind its valid bit, which is reset.
  always_ff @(posedge clk_i) begin
    if (tag_we) tag_q[cur_idx] <= cur_tag;
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_rw_o    = mem_rw_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic        refill_q, refill_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Only the first lookup of a request counts; the post-fill re-compare is bookkeeping.
  always_comb begin
    refill_d   = refill_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_ALLOCATE && mem_ready_i) refill_d = 1'b1;
    else if (state_q == S_IDLE)               refill_d = 1'b0;
    if (state_q == S_COMPARE && !refill_q) begin
      if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: external data array and main memory modelled here, results checked against a
// transparent-cache memory model (loads return the last stored word). Define CACHE_STATS_EN to cover the counters.
`timescale 1ns/1ps
module tb_cache_ctrl_fsm;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         cpu_valid_i, cpu_rw_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic         cpu_ready_o;
  logic [9:0]   data_index_o;
  logic         data_we_o;
  logic [127:0] data_write_o, data_read_i;
  logic         mem_valid_o, mem_rw_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o, mem_rdata_i;
  logic         mem_ready_i;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  cache_ctrl_fsm dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cpu_valid_i  (cpu_valid_i),
    .cpu_rw_i     (cpu_rw_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_ready_o  (cpu_ready_o),
    .data_index_o (data_index_o),
    .data_we_o    (data_we_o),
    .data_write_o (data_write_o),
    .data_read_i  (data_read_i),
    .mem_valid_o  (mem_valid_o),
    .mem_rw_o     (mem_rw_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ready_i  (mem_ready_i)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // External single-port data array: combinational read, synchronous write.
  logic [127:0] darray [1024];
  assign data_read_i = darray[data_index_o];
  always @(posedge clk_i) if (data_we_o) darray[data_index_o] <= data_write_o;

  // Main memory (line granularity) and the reference view of memory the core should observe.
  logic [127:0] main_mem [logic [31:0]];
  logic [31:0]  ref_mem  [logic [31:0]];
  bit           m_valid [1024];
  bit           m_dirty [1024];
  logic [17:0]  m_tag   [1024];
  int           exp_hits, exp_misses;

  int checks = 0;
  int errors = 0;

  int           o_lat, o_pulses, o_unstable, o_leak;
  bit           o_wb, o_fill;
  logic [31:0]  o_wb_addr, o_fill_addr, o_rdata;
  logic [127:0] o_wb_data;

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [127:0] main_line(input logic [31:0] la);
    logic [127:0] l;
    if (main_mem.exists(la)) return main_mem[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word({la[29:0], 2'b00} + 32'(w));
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] wa);
    logic [127:0] l;
    if (ref_mem.exists(wa)) return ref_mem[wa];
    l = main_line(wa >> 2);
    return l[{wa[1:0], 5'b0} +: 32];
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] byte_addr);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = ref_word((byte_addr >> 2) + 32'(w));
    return l;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    ref_mem.delete();
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // One request with memory acting as responder; wbd/fd = extra cycles before mem_ready_i per phase.
  task automatic run_req(input string name, input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                         input int wbd, input int fd);
    logic [9:0]   idx;
    logic [17:0]  tg;
    bit           hit, exp_wb, done;
    logic [31:0]  exp_wb_addr, exp_fill_addr, exp_rdata;
    logic [127:0] exp_wb_data;
    int           exp_lat, wbc, fc;

    idx           = addr[13:4];
    tg            = addr[31:14];
    hit           = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb        = !hit && m_valid[idx] && m_dirty[idx];
    exp_wb_addr   = {m_tag[idx], idx, 4'b0};
    exp_wb_data   = ref_line(exp_wb_addr);
    exp_fill_addr = {tg, idx, 4'b0};
    // Cycles: one lookup, each memory phase lasts its delay plus the ready cycle, then the re-compare.
    exp_lat = hit ? 1 : (exp_wb ? 2 + (wbd + 1) + (fd + 1) : 2 + (fd + 1));
    if (hit) exp_hits++; else exp_misses++;
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    if (rw) begin
      ref_mem[addr >> 2] = wd;
      m_dirty[idx]       = 1'b1;
    end
    exp_rdata = ref_word(addr >> 2);

    @(negedge clk_i);
    cpu_valid_i = 1'b1;
    cpu_rw_i    = rw;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    @(posedge clk_i);
    o_lat = 0; o_pulses = 0; o_unstable = 0; o_leak = 0; o_wb = 0; o_fill = 0;
    o_rdata = '0; wbc = 0; fc = 0; done = 0;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge clk_i);
      if (cpu_ready_o) begin
        o_pulses++;
        if (o_lat == 0) begin
          o_lat   = cyc;
          o_rdata = cpu_rdata_o;
        end
      end else if (cpu_rdata_o !== 32'h0) begin
        o_leak++;
      end
      if (o_lat != 0 && cyc > o_lat) done = 1;
      cpu_valid_i = 1'b0;
      cpu_rw_i    = 1'($urandom_range(0, 1));
      cpu_addr_i  = $urandom;
      cpu_wdata_i = $urandom;
      mem_ready_i = 1'b0;
      mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      if (mem_valid_o) begin
        if (mem_rw_o) begin
          if (wbc == 0) begin
            o_wb      = 1;
            o_wb_addr = mem_addr_o;
            o_wb_data = mem_wdata_o;
          end else if (mem_addr_o !== o_wb_addr || mem_wdata_o !== o_wb_data) begin
            o_unstable++;
          end
          wbc++;
          if (wbc == wbd + 1) begin
            mem_ready_i = 1'b1;
            main_mem[mem_addr_o >> 4] = mem_wdata_o;
          end
        end else begin
          if (fc == 0) begin
            o_fill      = 1;
            o_fill_addr = mem_addr_o;
          end else if (mem_addr_o !== o_fill_addr) begin
            o_unstable++;
          end
          fc++;
          if (fc == fd + 1) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = main_line(mem_addr_o >> 4);
          end
        end
      end
    end

    checks++;
    if (o_lat != exp_lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, o_lat, exp_lat);
    end
    checks++;
    if (o_pulses != 1) begin
      errors++; $display("FAIL %s ready_pulses got %0d want 1", name, o_pulses);
    end
    checks++;
    if (o_leak != 0 || o_unstable != 0) begin
      errors++; $display("FAIL %s rdata_leak/mem_unstable got %0d/%0d want 0/0", name, o_leak, o_unstable);
    end
    checks++;
    if (o_wb !== exp_wb || o_fill !== !hit) begin
      errors++; $display("FAIL %s wb/fill got %0b/%0b want %0b/%0b", name, o_wb, o_fill, exp_wb, !hit);
    end
    if (exp_wb && o_wb) begin
      checks++;
      if (o_wb_addr !== exp_wb_addr || o_wb_data !== exp_wb_data) begin
        errors++; $display("FAIL %s wb_line got %0h:%0h want %0h:%0h", name, o_wb_addr, o_wb_data,
                           exp_wb_addr, exp_wb_data);
      end
    end
    if (!hit && o_fill) begin
      checks++;
      if (o_fill_addr !== exp_fill_addr) begin
        errors++; $display("FAIL %s fill_addr got %0h want %0h", name, o_fill_addr, exp_fill_addr);
      end
    end
    if (!rw) begin
      checks++;
      if (o_rdata !== exp_rdata) begin
        errors++; $display("FAIL %s rdata got %0h want %0h", name, o_rdata, exp_rdata);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({cpu_ready_o, cpu_rdata_o} !== 33'h0) begin
      errors++; $display("FAIL %s cpu_out got %0h want 0", name, {cpu_ready_o, cpu_rdata_o});
    end
    checks++;
    if ({data_we_o, data_write_o, data_index_o} !== 139'h0) begin
      errors++; $display("FAIL %s data_out got %0h want 0", name, {data_we_o, data_write_o, data_index_o});
    end
    checks++;
    if ({mem_valid_o, mem_rw_o, mem_addr_o, mem_wdata_o} !== 162'h0) begin
      errors++; $display("FAIL %s mem_out got %0h want 0", name, {mem_valid_o, mem_rw_o, mem_addr_o, mem_wdata_o});
    end
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0;
    cpu_valid_i = 1'b0; cpu_rw_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    model_clear();
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    check_outputs_zero("reset");
`ifdef CACHE_STATS_EN
    checks++;
    if ({hit_cnt_o, miss_cnt_o} !== 64'h0) begin
      errors++; $display("FAIL reset counters got %0h want 0", {hit_cnt_o, miss_cnt_o});
    end
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_first_load();
    main_mem[32'h1] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    run_req("t1_load10", 1'b0, 32'h10, 32'h0, 0, 2);
    checks++;
    if (o_wb !== 1'b0 || o_fill_addr !== 32'h10 || o_rdata !== 32'h1111_1111) begin
      errors++; $display("FAIL t1 wb/fill_addr/rdata got %0b/%0h/%0h want 0/10/11111111", o_wb, o_fill_addr, o_rdata);
    end
  endtask

  task automatic test_store_hit();
    run_req("t2_store14", 1'b1, 32'h14, 32'hDEAD_BEEF, 0, 0);
    checks++;
    if (o_lat != 1 || (o_wb | o_fill) !== 1'b0) begin
      errors++; $display("FAIL t2 hit_lat/mem got %0d/%0b want 1/0", o_lat, o_wb | o_fill);
    end
    run_req("t2_load14", 1'b0, 32'h14, 32'h0, 0, 0);
    checks++;
    if (o_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL t2 reload got %0h want deadbeef", o_rdata);
    end
  endtask

  task automatic test_dirty_evict();
    run_req("t3_load4010", 1'b0, 32'h4010, 32'h0, 1, 1);
    checks++;
    if (o_wb_addr !== 32'h10 || o_wb_data[63:32] !== 32'hDEAD_BEEF || o_fill_addr !== 32'h4010) begin
      errors++; $display("FAIL t3 wb_addr/wb_word1/fill_addr got %0h/%0h/%0h want 10/deadbeef/4010",
                         o_wb_addr, o_wb_data[63:32], o_fill_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a, exp_b, d1, d3;
    logic        r1, r2, r3, r4;
    exp_a = ref_word(32'h4010 >> 2);
    exp_b = ref_word(32'h401C >> 2);
    exp_hits += 2;
    @(negedge clk_i);
    cpu_valid_i = 1'b1; cpu_rw_i = 1'b0; cpu_addr_i = 32'h4010;
    @(negedge clk_i);
    r1 = cpu_ready_o; d1 = cpu_rdata_o;
    cpu_addr_i = 32'h401C;
    @(negedge clk_i);
    r2 = cpu_ready_o;
    @(negedge clk_i);
    r3 = cpu_ready_o; d3 = cpu_rdata_o;
    cpu_valid_i = 1'b0;
    @(negedge clk_i);
    r4 = cpu_ready_o;
    checks++;
    if ({r1, r2, r3, r4} !== 4'b1010) begin
      errors++; $display("FAIL b2b ready_seq got %b want 1010", {r1, r2, r3, r4});
    end
    checks++;
    if (d1 !== exp_a || d3 !== exp_b) begin
      errors++; $display("FAIL b2b rdata got %0h/%0h want %0h/%0h", d1, d3, exp_a, exp_b);
    end
  endtask

  task automatic test_slow_mem();
    run_req("t4_clean_slow", 1'b0, 32'h200, 32'h0, 0, 5);
    run_req("t4_store", 1'b1, 32'h204, 32'h0BAD_F00D, 0, 0);
    run_req("t4_dirty_slow", 1'b0, 32'h4200, 32'h0, 5, 5);
    checks++;
    if (o_lat != 14 || o_pulses != 1) begin
      errors++; $display("FAIL t4 lat/pulses got %0d/%0d want 14/1", o_lat, o_pulses);
    end
  endtask

  task automatic test_reset_mid_wb();
    bit seen = 0;
    run_req("t5_setup", 1'b1, 32'h10, 32'hCAFE_F00D, 0, 0);
    @(negedge clk_i);
    cpu_valid_i = 1'b1; cpu_rw_i = 1'b0; cpu_addr_i = 32'h4010; cpu_wdata_i = '0;
    @(negedge clk_i);
    cpu_valid_i = 1'b0; cpu_addr_i = '0; mem_ready_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk_i);
      if (mem_valid_o && mem_rw_o) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL t5 wb_entered got 0 want 1");
    end
    rst_ni = 1'b0;
    model_clear();
    #1;
    check_outputs_zero("t5_async");
    @(posedge clk_i);
    #1;
    check_outputs_zero("t5_held");
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_req("t5_reload", 1'b0, 32'h10, 32'h0, 0, 1);
    checks++;
    if (o_wb !== 1'b0 || o_rdata !== 32'h1111_1111) begin
      errors++; $display("FAIL t5 wb/rdata got %0b/%0h want 0/11111111", o_wb, o_rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2);
      run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), a, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_cnt_o !== 32'(exp_hits) || miss_cnt_o !== 32'(exp_misses)) begin
      errors++; $display("FAIL rnd counters got %0d/%0d want %0d/%0d", hit_cnt_o, miss_cnt_o, exp_hits, exp_misses);
    end
`endif
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    reset_dut();
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_req("t6_load10a", 1'b0, 32'h10, 32'h0, 0, 0);
    run_req("t6_load10b", 1'b0, 32'h10, 32'h0, 0, 0);
    run_req("t6_store14", 1'b1, 32'h14, 32'h5A5A_5A5A, 0, 0);
    run_req("t6_load18",  1'b0, 32'h18, 32'h0, 0, 0);
    checks++;
    if (miss_cnt_o !== 32'd1 || hit_cnt_o !== 32'd3) begin
      errors++; $display("FAIL t6 miss/hit got %0d/%0d want 1/3", miss_cnt_o, hit_cnt_o);
    end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) darray[i] = '0;
    test_reset();
    test_first_load();
    test_store_hit();
    test_dirty_evict();
    test_back_to_back();
    test_slow_mem();
    test_reset_mid_wb();
    test_random();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
